fp_mul_pipe: RTL and testbench

FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

---
 rtl/fp_pkg.sv | 28 ++
 rtl/fp_round_rne.sv | 26 ++
 rtl/fp_mul_pipe.sv | 167 ++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point multiplier: flag bit positions,
// operand classes and the canonical quiet-NaN encoding.
package fp_pkg;

  localparam int FLAG_INEXACT   = 0;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_INVALID   = 3;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } fp_class_t;

  // Positive canonical qNaN for an n-bit word with an es-bit exponent, in the low n bits.
  function automatic logic [63:0] fp_qnan(input int n, input int es);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 64; i++) begin
      if (i >= n - 1 - es && i < n - 1) v[6'(i)] = 1'b1;
    end
    v[6'(n - es - 2)] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even of a normalised mantissa; a carry out of the mantissa
// bumps the exponent.
module fp_round_rne #(
  parameter int SS = 23,
  parameter int EW = 10
) (
  input  logic [SS-1:0]        mant,
  input  logic                 guard,
  input  logic                 round,
  input  logic                 sticky,
  input  logic signed [EW-1:0] exp_raw,
  output logic [SS-1:0]        mant_rnd,
  output logic signed [EW-1:0] exp_rnd,
  output logic                 carry
);

  logic        inc;
  logic [SS:0] sum;

  assign inc      = guard & (round | sticky | mant[0]);
  assign sum      = {1'b0, mant} + {{SS{1'b0}}, inc};
  assign carry    = sum[SS];
  assign mant_rnd = sum[SS-1:0];
  assign exp_rnd  = exp_raw + $signed({{(EW-1){1'b0}}, carry});

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage floating-point multiplier (classify/multiply, normalise,
// round/pack) with a single global advance for backpressure.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int N    = 32,
  parameter int ES   = 8,
  parameter int SS   = N - ES - 1,
  parameter int BIAS = 2**(ES-1) - 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic [3:0]   flags
);

  localparam int PW = 2*SS + 2;
  localparam int EW = ES + 2;
  localparam logic signed [EW-1:0] BIAS_E  = EW'(BIAS);
  localparam logic signed [EW-1:0] EXP_INF = EW'(2**ES - 1);
  localparam logic [N-1:0]         QNAN    = N'(fp_qnan(N, ES));

  function automatic fp_class_t classify(input logic [N-1:0] x);
    if (x[N-2:SS] == '0) return CLS_ZERO;
    if (x[N-2:SS] == '1) return (x[SS-1:0] == '0) ? CLS_INF : CLS_NAN;
    return CLS_NORM;
  endfunction

  function automatic fp_class_t combine(input fp_class_t ca, input fp_class_t cb);
    if (ca == CLS_NAN || cb == CLS_NAN) return CLS_NAN;
    if ((ca == CLS_INF && cb == CLS_ZERO) || (ca == CLS_ZERO && cb == CLS_INF)) return CLS_NAN;
    if (ca == CLS_INF || cb == CLS_INF) return CLS_INF;
    if (ca == CLS_ZERO || cb == CLS_ZERO) return CLS_ZERO;
    return CLS_NORM;
  endfunction

  // Exponent range saturation for the finite path; returns {flags, word}.
  function automatic logic [N+3:0] pack_norm(input logic sgn, input logic signed [EW-1:0] e,
                                             input logic [SS-1:0] m, input logic cy,
                                             input logic lossy);
    logic [3:0]   f;
    logic [N-1:0] w;
    f = '0;
    w = {sgn, {(N-1){1'b0}}};
    if (e >= EXP_INF) begin
      w[N-2:SS]         = '1;
      f[FLAG_OVERFLOW]  = 1'b1;
      f[FLAG_INEXACT]   = 1'b1;
    end else if (e[EW-1] || e == '0) begin
      f[FLAG_UNDERFLOW] = 1'b1;
      f[FLAG_INEXACT]   = 1'b1;
    end else begin
      w[N-2:SS]         = e[ES-1:0];
      w[SS-1:0]         = cy ? '0 : m;
      f[FLAG_INEXACT]   = lossy;
    end
    return {f, w};
  endfunction

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // S1: classify operands, multiply significands, sum exponents
  logic [PW-1:0]        ma_x, mb_x, prod_s1;
  logic signed [EW-1:0] exp_s1;
  assign ma_x    = {{(SS+1){1'b0}}, 1'b1, a[SS-1:0]};
  assign mb_x    = {{(SS+1){1'b0}}, 1'b1, b[SS-1:0]};
  assign prod_s1 = ma_x * mb_x;
  assign exp_s1  = $signed({2'b00, a[N-2:SS]}) + $signed({2'b00, b[N-2:SS]}) - BIAS_E;

  logic                 vld_p0, sign_p0;
  fp_class_t            cls_p0;
  logic [PW-1:0]        prod_p0;
  logic signed [EW-1:0] exp_p0;

  // S2: normalise so the leading one sits at bit 2*SS, keeping the shifted-out bit as sticky
  logic [PW-2:0]        norm_s2;
  logic                 lost_s2;
  logic signed [EW-1:0] exp_s2;
  assign norm_s2 = prod_p0[PW-1] ? prod_p0[PW-1:1] : prod_p0[PW-2:0];
  assign lost_s2 = prod_p0[PW-1] & prod_p0[0];
  assign exp_s2  = exp_p0 + $signed({{(EW-1){1'b0}}, prod_p0[PW-1]});

  logic                 vld_p1, sign_p1, guard_p1, round_p1, sticky_p1;
  fp_class_t            cls_p1;
  logic [SS-1:0]        mant_p1;
  logic signed [EW-1:0] exp_p1;

  // S3: round, resolve special classes and exponent range, pack
  logic [SS-1:0]        mant_rnd;
  logic signed [EW-1:0] exp_rnd;
  logic                 carry_rnd;
  logic [N-1:0]         res_s3;
  logic [3:0]           flags_s3;

  fp_round_rne #(.SS(SS), .EW(EW)) u_round (
    .mant     (mant_p1),
    .guard    (guard_p1),
    .round    (round_p1),
    .sticky   (sticky_p1),
    .exp_raw  (exp_p1),
    .mant_rnd (mant_rnd),
    .exp_rnd  (exp_rnd),
    .carry    (carry_rnd)
  );

  always_comb begin
    res_s3   = {sign_p1, {(N-1){1'b0}}};
    flags_s3 = '0;
    case (cls_p1)
      CLS_NAN: begin
        res_s3                 = {sign_p1, QNAN[N-2:0]};
        flags_s3[FLAG_INVALID] = 1'b1;
      end
      CLS_INF:  res_s3 = {sign_p1, {ES{1'b1}}, {SS{1'b0}}};
      CLS_ZERO: res_s3 = {sign_p1, {(N-1){1'b0}}};
      default:  {flags_s3, res_s3} = pack_norm(sign_p1, exp_rnd, mant_rnd, carry_rnd,
                                               guard_p1 | round_p1 | sticky_p1);
    endcase
  end

  logic         vld_p2;
  logic [N-1:0] res_p2;
  logic [3:0]   flags_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (advance) begin
      vld_p0 <= in_valid;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      sign_p0   <= a[N-1] ^ b[N-1];
      cls_p0    <= combine(classify(a), classify(b));
      prod_p0   <= prod_s1;
      exp_p0    <= exp_s1;
      sign_p1   <= sign_p0;
      cls_p1    <= cls_p0;
      mant_p1   <= norm_s2[PW-3:SS];
      guard_p1  <= norm_s2[SS-1];
      round_p1  <= norm_s2[SS-2];
      sticky_p1 <= (|norm_s2[SS-3:0]) | lost_s2;
      exp_p1    <= exp_s2;
      res_p2    <= res_s3;
      flags_p2  <= flags_s3;
    end
  end

  assign out_valid = vld_p2;
  assign result    = vld_p2 ? res_p2 : '0;
  assign flags     = vld_p2 ? flags_p2 : '0;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Randomised and directed bench for fp_mul_pipe against an arithmetic reference
// model of single-precision multiplication.
module tb_fp_mul_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  flags;

  fp_mul_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
    int          acc;
    bit          lat;
  } ent_t;

  ent_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   recv     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, want);
    end
  endtask

  // Exact significand product, then nearest-even rounding by remainder comparison.
  function automatic logic [35:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    logic              sgn, xnan, ynan, xinf, yinf, xzero, yzero, inexact;
    longint unsigned   m, q, rem, half;
    int                e, k;
    sgn   = x[31] ^ y[31];
    xnan  = (x[30:23] == 8'hFF) && (x[22:0] != 0);
    ynan  = (y[30:23] == 8'hFF) && (y[22:0] != 0);
    xinf  = (x[30:23] == 8'hFF) && (x[22:0] == 0);
    yinf  = (y[30:23] == 8'hFF) && (y[22:0] == 0);
    xzero = (x[30:23] == 8'h00);
    yzero = (y[30:23] == 8'h00);
    if (xnan || ynan || (xinf && yzero) || (yinf && xzero))
      return {4'b1000, sgn, 8'hFF, 1'b1, 22'b0};
    if (xinf || yinf) return {4'b0000, sgn, 8'hFF, 23'b0};
    if (xzero || yzero) return {4'b0000, sgn, 31'b0};
    m = 64'({1'b1, x[22:0]}) * 64'({1'b1, y[22:0]});
    k = (m >= (64'd1 << 47)) ? 24 : 23;
    e = int'(x[30:23]) + int'(y[30:23]) - 127 + (k - 23);
    q    = m >> k;
    rem  = m & ((64'd1 << k) - 1);
    half = 64'd1 << (k - 1);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    inexact = (rem != 0);
    if (e >= 255) return {4'b0101, sgn, 8'hFF, 23'b0};
    if (e <= 0)   return {4'b0011, sgn, 31'b0};
    return {3'b000, inexact, sgn, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0]  ex;
    logic [22:0] mt;
    int          sel;
    sel = int'($urandom_range(0, 15));
    mt  = 23'($urandom);
    case (sel)
      0:       ex = 8'h00;
      1:       begin ex = 8'hFF; mt = 23'h0; end
      2:       begin ex = 8'hFF; mt = mt | 23'h1; end
      3, 4:    ex = 8'($urandom_range(1, 20));
      5, 6:    ex = 8'($urandom_range(230, 254));
      7:       begin ex = 8'($urandom_range(100, 154)); mt = 23'h7FFFFF; end
      default: ex = 8'($urandom_range(1, 254));
    endcase
    return {1'($urandom), ex, mt};
  endfunction

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input logic [31:0] x, input logic [31:0] y,
                      input logic [35:0] want, input bit lat);
    int   n;
    ent_t e;
    n        = 0;
    in_valid = 1'b1;
    a        = x;
    b        = y;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", {31'b0, in_ready}, 32'd1);
    end else begin
      e.flg = want[35:32];
      e.res = want[31:0];
      e.acc = cyc;
      e.lat = lat;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", result, 32'hDEAD_BEEF);
        end else begin
          e = exp_q.pop_front();
          recv++;
          chk("result", result, e.res);
          chk("flags", {28'b0, flags}, {28'b0, e.flg});
          if (e.lat) chk("latency", 32'(cyc - e.acc), 32'd3);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit done;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_flags", {28'b0, flags}, 32'd0);
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);

    out_ready = 1'b1;
    send(32'h3FC00000, 32'h40000000, {4'b0000, 32'h40400000}, 1'b1); drain();
    send(32'h3F800001, 32'h3F800001, {4'b0001, 32'h3F800002}, 1'b1); drain();
    send(32'h7F000000, 32'h7F000000, {4'b0101, 32'h7F800000}, 1'b1); drain();
    send(32'h00800000, 32'h3F000000, {4'b0011, 32'h00000000}, 1'b1); drain();
    send(32'h7F800000, 32'h00000000, {4'b1000, 32'h7FC00000}, 1'b1); drain();
    send(32'hFF800000, 32'h40000000, {4'b0000, 32'hFF800000}, 1'b1); drain();
    send(32'hBF800000, 32'h7FC00001, {4'b1000, 32'hFFC00000}, 1'b1); drain();

    // six back-to-back operands with a downstream stall
    recv = 0;
    fork
      begin
        logic [31:0] x, y;
        for (int i = 0; i < 6; i++) begin
          x = 32'h3F800000 | 32'(i + 1);
          y = 32'h40000000 + (32'(i) << 23);
          send(x, y, ref_mul(x, y), 1'b0);
        end
      end
      begin
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (6) @(negedge clk);
        chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("stall_count", 32'(recv), 32'd6);

    // reset with three operations in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(32'h40400000, 32'h40400000, {4'b0000, 32'h41100000}, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    send(32'h40A00000, 32'hC0000000, {4'b0000, 32'hC1200000}, 1'b1);
    drain();

    // randomised traffic with random backpressure
    done = 1'b0;
    fork
      begin
        logic [31:0] x, y;
        for (int i = 0; i < 300; i++) begin
          x = rand_op();
          y = rand_op();
          send(x, y, ref_mul(x, y), 1'b0);
          if ($urandom_range(0, 7) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
